// File: rtl/caxi4interconnect_dwc_downconv_rdata_pack_if.sv
`default_nettype none
// ============================================================================
// Module      : caxi4interconnect_dwc_downconv_rdata_pack_if
// Description : Command, slave-side R and master-side R signals of the DWC
//               read-data packer, bundled for port connection.
// Revision    : 1.0 - initial release
// ============================================================================
interface caxi4interconnect_dwc_downconv_rdata_pack_if #(
  parameter int MASTER_DATA_WIDTH = 64,
  parameter int SLAVE_DATA_WIDTH  = 32,
  parameter int ID_WIDTH          = 1
);
  // Held read command
  logic                         cmd_valid;
  logic                         cmd_ready;
  logic [ID_WIDTH-1:0]          cmd_id;
  logic [7:0]                   cmd_len;
  logic [2:0]                   cmd_mst_size;
  logic [2:0]                   cmd_slv_size;
  logic [6:0]                   cmd_addr;
  // Narrow slave-side read data
  logic                         SLAVE_RVALID;
  logic                         SLAVE_RREADY;
  logic [SLAVE_DATA_WIDTH-1:0]  SLAVE_RDATA;
  logic [1:0]                   SLAVE_RRESP;
  logic                         SLAVE_RLAST;
  // Wide master-side read data
  logic                         MASTER_RVALID;
  logic                         MASTER_RREADY;
  logic [MASTER_DATA_WIDTH-1:0] MASTER_RDATA;
  logic [1:0]                   MASTER_RRESP;
  logic                         MASTER_RLAST;
  logic [ID_WIDTH-1:0]          MASTER_RID;
  // Framing diagnostic
  logic                         rlast_err;

  // Packer side: drives the pop, slave ready and the master R channel
  modport master (
    input  cmd_valid, cmd_id, cmd_len, cmd_mst_size, cmd_slv_size, cmd_addr,
    input  SLAVE_RVALID, SLAVE_RDATA, SLAVE_RRESP, SLAVE_RLAST,
    input  MASTER_RREADY,
    output cmd_ready, SLAVE_RREADY,
    output MASTER_RVALID, MASTER_RDATA, MASTER_RRESP, MASTER_RLAST, MASTER_RID,
    output rlast_err
  );

  // Environment side: command holder, slave R source and master R sink
  modport slave (
    output cmd_valid, cmd_id, cmd_len, cmd_mst_size, cmd_slv_size, cmd_addr,
    output SLAVE_RVALID, SLAVE_RDATA, SLAVE_RRESP, SLAVE_RLAST,
    output MASTER_RREADY,
    input  cmd_ready, SLAVE_RREADY,
    input  MASTER_RVALID, MASTER_RDATA, MASTER_RRESP, MASTER_RLAST, MASTER_RID,
    input  rlast_err
  );
endinterface
`default_nettype wire

// File: rtl/caxi4interconnect_dwc_downconv_rdata_pack.sv
`default_nettype none
// ============================================================================
// Module      : caxi4interconnect_dwc_downconv_rdata_pack
// Description : Packs narrow slave R beats into wide master R beats for the
//               data-width down-converter, merges responses, generates master
//               RLAST and flags slave RLAST framing errors.
// Revision    : 1.0 - initial release
// ============================================================================
module caxi4interconnect_dwc_downconv_rdata_pack #(
  parameter int MASTER_DATA_WIDTH = 64,
  parameter int SLAVE_DATA_WIDTH  = 32,
  parameter int ID_WIDTH          = 1
) (
  input  logic ACLK,
  input  logic sysReset,
  caxi4interconnect_dwc_downconv_rdata_pack_if.master bus
);

  localparam int NSEG     = MASTER_DATA_WIDTH / SLAVE_DATA_WIDTH;
  localparam int SW_LOG   = $clog2(SLAVE_DATA_WIDTH / 8);
  localparam int MW_BYTES = MASTER_DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_OUT   = 2'd2
  } state_t;

  state_t                       state;
  logic [6:0]                   addr_cur;
  logic [7:0]                   beat_cnt;
  logic [7:0]                   remaining;
  logic                         first_beat;
  logic [MASTER_DATA_WIDTH-1:0] pack_buf;
  logic [1:0]                   resp_acc;
  logic                         slave_ready_q;
  logic                         mvalid_q;
  logic                         mlast_q;
  logic [ID_WIDTH-1:0]          mid_q;
  logic                         rlast_err_q;

  logic [6:0] lane_off;
  logic [6:0] seg_idx;
  logic       replicate;
  logic       last_slave_beat;
  logic [6:0] next_mst_addr;

  // Slave beats needed to fill a master beat starting at addr
  function automatic logic [7:0] slv_needed_f(input logic [6:0] addr,
                                              input logic [2:0] mst,
                                              input logic [2:0] slv);
    logic [8:0] span;
    logic [8:0] off;
    span = 9'd1 << mst;
    off  = {2'b00, addr} & (span - 9'd1) & ~((9'd1 << slv) - 9'd1);
    if (mst > slv)
      return 8'((span - off) >> slv);
    return 8'd1;
  endfunction

  // Round addr up to the next 2^mst boundary (no change when aligned)
  function automatic logic [6:0] align_up_f(input logic [6:0] addr,
                                            input logic [2:0] mst);
    logic [7:0] mask;
    mask = (8'd1 << mst) - 8'd1;
    return 7'(({1'b0, addr} + mask) & ~mask);
  endfunction

  // Numeric max, but an exclusive-okay alongside a plain okay is only okay
  function automatic logic [1:0] resp_merge_f(input logic [1:0] a,
                                              input logic [1:0] b);
    if ((a == 2'd1 && b == 2'd0) || (a == 2'd0 && b == 2'd1))
      return 2'd0;
    return (a > b) ? a : b;
  endfunction

  assign lane_off        = addr_cur & 7'(MW_BYTES - 1);
  assign seg_idx         = lane_off >> SW_LOG;
  assign replicate       = (bus.cmd_mst_size <= bus.cmd_slv_size);
  assign last_slave_beat = (beat_cnt == bus.cmd_len) && (remaining == 8'd1);
  assign next_mst_addr   = align_up_f(addr_cur, bus.cmd_mst_size);

  // Pop coincides with the handshake of the final master beat
  assign bus.cmd_ready     = mvalid_q & bus.MASTER_RREADY & mlast_q;
  assign bus.SLAVE_RREADY  = slave_ready_q;
  assign bus.MASTER_RVALID = mvalid_q;
  assign bus.MASTER_RDATA  = pack_buf;
  assign bus.MASTER_RRESP  = resp_acc;
  assign bus.MASTER_RLAST  = mlast_q;
  assign bus.MASTER_RID    = mid_q;
  assign bus.rlast_err     = rlast_err_q;

  // Packer state machine: load command, accumulate slave beats, present master beat
  always_ff @(posedge ACLK or negedge sysReset) begin
    if (!sysReset) begin
      state         <= S_IDLE;
      addr_cur      <= '0;
      beat_cnt      <= '0;
      remaining     <= '0;
      first_beat    <= 1'b0;
      pack_buf      <= '0;
      resp_acc      <= '0;
      slave_ready_q <= 1'b0;
      mvalid_q      <= 1'b0;
      mlast_q       <= 1'b0;
      mid_q         <= '0;
      rlast_err_q   <= 1'b0;
    end else begin
      rlast_err_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.cmd_valid) begin
            addr_cur      <= bus.cmd_addr;
            beat_cnt      <= '0;
            remaining     <= slv_needed_f(bus.cmd_addr, bus.cmd_mst_size, bus.cmd_slv_size);
            pack_buf      <= '0;
            resp_acc      <= '0;
            first_beat    <= 1'b1;
            slave_ready_q <= 1'b1;
            state         <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (bus.SLAVE_RVALID) begin
            for (int i = 0; i < NSEG; i++) begin
              if (replicate || seg_idx == 7'(i))
                pack_buf[i*SLAVE_DATA_WIDTH +: SLAVE_DATA_WIDTH] <= bus.SLAVE_RDATA;
            end
            resp_acc    <= first_beat ? bus.SLAVE_RRESP
                                      : resp_merge_f(resp_acc, bus.SLAVE_RRESP);
            first_beat  <= 1'b0;
            addr_cur    <= addr_cur + (7'd1 << bus.cmd_slv_size);
            rlast_err_q <= (bus.SLAVE_RLAST != last_slave_beat);
            remaining   <= remaining - 8'd1;
            if (remaining == 8'd1) begin
              slave_ready_q <= 1'b0;
              mvalid_q      <= 1'b1;
              mlast_q       <= (beat_cnt == bus.cmd_len);
              mid_q         <= bus.cmd_id;
              state         <= S_OUT;
            end
          end
        end
        S_OUT: begin
          if (bus.MASTER_RREADY) begin
            mvalid_q <= 1'b0;
            if (mlast_q) begin
              mlast_q <= 1'b0;
              state   <= S_IDLE;
            end else begin
              beat_cnt      <= beat_cnt + 8'd1;
              addr_cur      <= next_mst_addr;
              remaining     <= slv_needed_f(next_mst_addr, bus.cmd_mst_size, bus.cmd_slv_size);
              pack_buf      <= '0;
              resp_acc      <= '0;
              first_beat    <= 1'b1;
              slave_ready_q <= 1'b1;
              state         <= S_ACCUM;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/caxi4interconnect_dwc_downconv_rdata_pack.md
# caxi4interconnect_dwc_downconv_rdata_pack

Read-data packer for the data-width down-converter (DWC). It consumes one held read command per master burst and collects narrow slave-side R beats. It packs them into wide master-side R beats, merges their responses and generates master RLAST. It sits on the R return path, after the DWC read command holding register that already splits master bursts into slave beats.

## Interface
- MASTER_DATA_WIDTH, 64, master R data width in bits; power of 2, 32..1024.
- SLAVE_DATA_WIDTH, 32, slave R data width in bits; power of 2, 32..MASTER_DATA_WIDTH.
- ID_WIDTH, 1, RID width.
- ACLK  in  1  clock; all logic rising-edge.
- sysReset  in  1  reset, asynchronous, active-low.
- cmd_valid  in  1  held command available.
- cmd_ready  out  1  single-cycle pop of held command.
- cmd_id  in  ID_WIDTH  master ARID.
- cmd_len  in  8  master ARLEN.
- cmd_mst_size  in  3  master ARSIZE.
- cmd_slv_size  in  3  slave beat size; equals min(cmd_mst_size, log2(SLAVE_DATA_WIDTH/8)).
- cmd_addr  in  7  master ARADDR[6:0].
- SLAVE_RVALID  in  1, SLAVE_RREADY  out  1.
- SLAVE_RDATA  in  SLAVE_DATA_WIDTH, SLAVE_RRESP  in  2, SLAVE_RLAST  in  1.
- MASTER_RVALID  out  1, MASTER_RREADY  in  1.
- MASTER_RDATA  out  MASTER_DATA_WIDTH, MASTER_RRESP  out  2, MASTER_RLAST  out  1, MASTER_RID  out  ID_WIDTH.
- rlast_err  out  1  one-cycle pulse when slave RLAST disagrees with expected framing.

## Operation
- Bursts arriving here are INCR only; WRAP and FIXED bursts are split into INCR upstream.
- Command fields stay stable from cmd_valid until cmd_ready.
- States: IDLE, ACCUM, OUT.
- IDLE:
  - On cmd_valid, load addr_cur = cmd_addr and beat_cnt = 0.
  - Compute slv_needed for the first master beat, then go to ACCUM.
  - Clear the pack buffer and merged resp.
- slv_needed, when cmd_mst_size > cmd_slv_size:
  - Compute (2^mst − (addr_cur & (2^mst−1) & ~(2^slv−1))) >> slv.
  - For master beats after the first, this reduces to 2^(mst−slv).
- slv_needed, when cmd_mst_size <= cmd_slv_size: 1.
- ACCUM: SLAVE_RREADY = 1. On each slave handshake:
  - Write SLAVE_RDATA into master lanes [addr_cur mod (MW/8) aligned down to SW/8] of the buffer. If cmd_mst_size <= cmd_slv_size, replicate SLAVE_RDATA across all MW/SW segments instead.
  - Merge resp: take the numeric max, except that an EXOKAY (1) merged with any OKAY (0) yields OKAY.
  - addr_cur += 2^slv.
  - Decrement the remaining count; when it reaches 0, go to OUT.
- Lanes not written by a slave beat read 0.
- OUT:
  - MASTER_RVALID = 1.
  - MASTER_RID = cmd_id.
  - MASTER_RLAST = (beat_cnt == cmd_len).
- OUT, on MASTER_RREADY when not the last master beat:
  - beat_cnt++, addr_cur aligns up to the next 2^mst boundary.
  - Clear the buffer and resp, reload slv_needed, go to ACCUM.
- OUT, on MASTER_RREADY for the last master beat: pulse cmd_ready, go to IDLE.
- rlast_err pulses on either mismatch:
  - slave RLAST = 1 on a slave beat that is not the final slave beat of the burst;
  - slave RLAST = 0 on the final slave beat.
- Framing continues unchanged after rlast_err.
- Address arithmetic is 7-bit modulo 128; master beats never cross 2^mst boundaries.

## Timing
- Reset: state IDLE; every output 0 (cmd_ready, SLAVE_RREADY, MASTER_RVALID, MASTER_RDATA, MASTER_RRESP, MASTER_RLAST, MASTER_RID, rlast_err); buffer, counters and resp cleared.
- Reset asserted mid-burst: immediate return to IDLE; the partial buffer is discarded and no cmd_ready is issued.
- SLAVE_RREADY is high only in ACCUM; MASTER_RVALID is high only in OUT. They are never high together.
- Latency:
  - IDLE to ACCUM: 1 cycle after cmd_valid.
  - MASTER_RVALID rises the cycle after the last contributing slave handshake.
  - ACCUM resumes the cycle after the master handshake.
- Under MASTER_RREADY low, MASTER_RVALID, RDATA, RRESP, RLAST and RID hold stable.
- cmd_ready is high for exactly one cycle, coincident with the final master handshake. A new cmd_valid is sampled in IDLE on the following cycle.
- MASTER_RDATA/RRESP/RLAST/RID are registered outputs.

## Test plan
- Setup for all cases: MW=64, SW=32, mst_size=3, slv_size=2.
- Aligned: addr=0x00, len=1; slave data 0xA0,0xA1,0xB0,0xB1 (all OKAY) -> RDATA 0x000000A1_000000A0 then 0x000000B1_000000B0; RLAST on beat 2; one cmd_ready.
- Unaligned: addr=0x04, len=0; one slave beat 0xDEADBEEF -> single master beat RDATA 0xDEADBEEF_00000000, RLAST=1, after exactly 1 slave beat.
- Narrow master: mst_size=2, slv_size=2, addr=0x04, len=1; beats 0x11111111, 0x22222222 -> RDATA 0x11111111_11111111, then 0x22222222_22222222.
- Resp merge: aligned len=0 with beats OKAY then SLVERR -> RRESP=2; beats EXOKAY,EXOKAY -> 1; beats EXOKAY,OKAY -> 0.
- Backpressure and reset:
  - Hold MASTER_RREADY low 5 cycles in OUT -> outputs stable, SLAVE_RREADY=0.
  - Assert sysReset after 1 of 2 slave beats -> all outputs 0 and no cmd_ready.
  - Next command after reset packs correctly.
- Framing error: slave RLAST=1 on the first of 2 beats -> rlast_err pulses 1 cycle; master beat still formed from both beats.
